// File: rtl/wb_axis_in_fifo.sv
// Wishbone slave to AXI-Stream input stage: buffers X[n] samples in a small
// show-ahead FIFO and raises ss_tlast on the data_length-th beat.
module wb_axis_in_fifo #(
  parameter int pDATA_WIDTH = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_dat_i,
  input  logic [31:0]            wbs_adr_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  output logic                   ss_tvalid,
  output logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tlast,
  input  logic                   ss_tready
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [FIFO_DEPTH-1:0][pDATA_WIDTH-1:0] r_mem;
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic [31:0]   r_len, r_pushed, r_sent, r_dat;
  logic          r_done, r_ovf, r_ack;

  logic          w_empty, w_full, w_req, w_x_wr, w_len_wr, w_room;
  logic          w_stall, w_acc, w_push, w_drop, w_pop, w_last;
  logic [AW:0]   w_count;
  logic [7:0]    w_adr;
  logic [31:0]   w_status, w_rdata, w_len_next;
  logic          w_unused;

  assign w_unused = ^wbs_adr_i[31:8];

  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_count  = r_wr_ptr - r_rd_ptr;

  assign w_adr    = wbs_adr_i[7:0];
  assign w_req    = wbs_stb_i & wbs_cyc_i & ~r_ack;
  assign w_x_wr   = wbs_we_i & (w_adr == 8'h80);
  assign w_len_wr = wbs_we_i & (w_adr == 8'h10);
  assign w_room   = (r_pushed < r_len);
  // Only a sample write that would actually be stored waits for space;
  // excess writes are acked and dropped even when the FIFO is full.
  assign w_stall  = w_req & w_x_wr & w_full & w_room;
  assign w_acc    = w_req & ~w_stall;
  assign w_push   = w_acc & w_x_wr & w_room;
  assign w_drop   = w_acc & w_x_wr & ~w_room;

  assign w_pop    = ~w_empty & ss_tready;
  assign w_last   = ~w_empty & (r_sent == r_len - 32'd1);

  assign ss_tvalid = ~w_empty;
  assign ss_tdata  = r_mem[r_rd_ptr[AW-1:0]];
  assign ss_tlast  = w_last;
  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;

  assign w_status = {16'h0, 8'(w_count), 4'h0, r_ovf, r_done, w_full, w_empty};

  always_comb begin
    w_rdata = '0;
    if (!wbs_we_i) begin
      case (w_adr)
        8'h10:   w_rdata = r_len;
        8'h88:   w_rdata = w_status;
        default: w_rdata = '0;
      endcase
    end
  end

  always_comb begin
    w_len_next = r_len;
    for (int b = 0; b < 4; b++)
      if (wbs_sel_i[b]) w_len_next[8*b +: 8] = wbs_dat_i[8*b +: 8];
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wbs_dat_i[pDATA_WIDTH-1:0];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_len    <= '0;
      r_pushed <= '0;
      r_sent   <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_ack <= w_acc;
      r_dat <= w_acc ? w_rdata : '0;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      // A new data_length starts a fresh set; buffered samples still drain.
      if (w_acc & w_len_wr) begin
        r_len    <= w_len_next;
        r_pushed <= '0;
        r_sent   <= '0;
        r_done   <= 1'b0;
        r_ovf    <= 1'b0;
      end else begin
        if (w_push)          r_pushed <= r_pushed + 32'd1;
        if (w_pop)           r_sent   <= r_sent + 32'd1;
        if (w_pop & w_last)  r_done   <= 1'b1;
        if (w_drop)          r_ovf    <= 1'b1;
      end
    end
  end
endmodule

// File: doc/wb_axis_in_fifo.md
# wb_axis_in_fifo

Wishbone-slave-to-AXI-Stream input stage that feeds the FIR's `ss_*` stream port inside the user-project Wishbone bridge. The firmware writes the data length and then X[n] samples over Wishbone. Samples are buffered in a small FIFO and presented as an AXI-Stream master, with `ss_tlast` generated on the data-length-th beat. The bridge's address decoder routes offsets 0x10, 0x80–0x83 and 0x88 to this block.

## Interface
- `pDATA_WIDTH`, default 32: stream and Wishbone data width.
- `FIFO_DEPTH`, default 4: sample buffer depth. Must be a power of two, at least 2.
- `wb_clk_i` in 1: single clock for Wishbone and stream.
- `wb_rst_i` in 1: reset; synchronous, active-high.
- `wbs_stb_i` in 1: Wishbone strobe.
- `wbs_cyc_i` in 1: Wishbone cycle.
- `wbs_we_i` in 1: write enable.
- `wbs_sel_i` in 4: byte enables.
- `wbs_dat_i` in 32: write data.
- `wbs_adr_i` in 32: address; only `[7:0]` is decoded.
- `wbs_ack_o` out 1: registered acknowledge, one cycle wide.
- `wbs_dat_o` out 32: read data; valid while `wbs_ack_o` is high, 0 otherwise.
- `ss_tvalid` out 1: stream valid.
- `ss_tdata` out pDATA_WIDTH: stream data.
- `ss_tlast` out 1: last beat of the data set.
- `ss_tready` in 1: FIR ready.

## Operation
- **Register map** (offset is `adr[7:0]`):
  - 0x10 data_length (r/w).
    - A write applies per-byte `wbs_sel_i` to `len_q`.
    - The same write also clears `pushed`, `sent`, `done` and `ovf`. It does not flush the FIFO.
  - 0x80 X[n] (write-only).
    - A write pushes the full 32-bit `wbs_dat_i`; `wbs_sel_i` is ignored.
    - A read returns 0.
  - 0x88 status (read-only).
    - bit0 = fifo_empty, bit1 = fifo_full, bit2 = done, bit3 = ovf.
    - bits[15:8] = fifo count, zero-extended.
    - All other bits are 0.
  - Any other offset: acked, writes ignored, reads return 0.
- **Transfer accept.** A transfer is accepted when `stb & cyc & ~wbs_ack_o & ~stall`.
  - `stall` is defined as (0x80 write & fifo_full & `pushed < len_q`).
  - While stalled, the master simply waits with no ack. There is no error and no timeout.
- **Push.** An accepted 0x80 write with `pushed < len_q` writes to `mem[wr_ptr]` and increments `wr_ptr` and `pushed`.
- **Excess writes.** A write accepted with `pushed >= len_q` (this includes `len_q == 0`) is acked but dropped, and sets sticky `ovf`.
- **FIFO.**
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits.
  - Empty when the pointers are equal; full when the MSBs differ and the rest are equal.
  - Output is show-ahead: `ss_tvalid = ~empty`, `ss_tdata = mem[rd_ptr]`.
- **Pop.** A pop happens on `ss_tvalid & ss_tready`; it increments `rd_ptr` and `sent`.
- **Last beat.** `ss_tlast = ss_tvalid & (sent == len_q - 1)`.
  - A handshake with `ss_tlast` high sets `done`.
  - `done` stays set until the next 0x10 write or reset.
- **Simultaneous push and pop.**
  - Both take effect in the same cycle and the count is unchanged.
  - fifo_full is evaluated on registered state, so a full FIFO with a concurrent pop still stalls the write for that cycle.
- **Counters.** `pushed` and `sent` are 32 bits; no wrap can occur because both are bounded by `len_q`.
- **data_length write while a stream is in flight.**
  - FIFO contents still drain.
  - `ss_tlast` is computed against the new `len_q` and the cleared `sent`.
  - Firmware is responsible for writing 0x10 only when status shows empty.

## Timing
- **Reset** (synchronous, `wb_rst_i` sampled high at a clock edge):
  - `wbs_ack_o`=0, `wbs_dat_o`=0, `ss_tvalid`=0, `ss_tlast`=0, `ss_tdata`=mem[0] (don't-care).
  - Pointers, `pushed`, `sent`, `len_q`, `done` and `ovf` all reset to 0.
  - Reset mid-transfer drops any pending ack and discards the FIFO contents.
- **Wishbone.**
  - Accept in cycle N; `wbs_ack_o` is high in cycle N+1 for exactly one cycle.
  - A held strobe cannot re-accept during the ack cycle.
  - Minimum transfer is 2 cycles; back-to-back accepts are possible every 2 cycles.
- **Read data.** `wbs_dat_o` is registered at accept and reflects state as of cycle N, before that cycle's push or pop.
- **Push to stream.** A push accepted in cycle N makes the sample visible on `ss_tvalid`/`ss_tdata` in cycle N+1, when the FIFO was empty.
- **Stream throughput.** One beat per cycle while not empty. `ss_tdata` and `ss_tlast` are stable while `ss_tvalid & ~ss_tready`.
- **Status timing.** `done` is visible to a status read accepted one cycle after the tlast handshake.

## Test plan
- **Reset and basic stream.**
  - Stimulus: reset, then write 0x10=3, then push 0x11, 0x22, 0x33 with `ss_tready`=1.
  - Required: beats 0x11, 0x22, 0x33 in order, `ss_tlast` only on 0x33.
  - Required: status read = 0x0000_0005 (empty and done).
- **Backpressure and stall.**
  - Stimulus: `len_q`=8, `ss_tready`=0, push 5 words.
  - Required: the 5th write gets no ack while status shows count=4 and full.
  - Required: raising `ss_tready` for 1 cycle lets the 5th write ack within 2 cycles, and the first beat output is the first word pushed.
- **Overflow.**
  - Stimulus: `len_q`=2, push 3 words.
  - Required: all 3 acked, only 2 beats produced, status bit3=1.
  - Required: a following 0x10 write clears bits 3 and 2.
- **Simultaneous push and pop.**
  - Stimulus: `len_q`=16, `ss_tready`=1 continuously, push every 2 cycles.
  - Required: count never exceeds 1, 16 beats produced, tlast on the 16th, no stall.
- **Zero length and stray addresses.**
  - Stimulus: `len_q`=0, push one word.
  - Required: no `ss_tvalid`, ovf=1.
  - Stimulus: read 0x84 and 0x20.
  - Required: both acked with data 0.
- **Mid-stream reset.**
  - Stimulus: `len_q`=4, 2 words buffered with `ss_tready`=0, assert `wb_rst_i` for 1 cycle.
  - Required: `ss_tvalid`=0 next cycle, status=0x0000_0001, `len_q` reads 0.
